// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-read-port register file.
package rf_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned NRD_MAX      = 4;
  localparam int unsigned AW_DEFAULT   = $clog2(NREG_DEFAULT);

  typedef logic [AW_DEFAULT-1:0]   reg_idx_t;
  typedef logic [XLEN_DEFAULT-1:0] word_t;

  // x0 is hardwired to zero and never tracked as pending.
  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard feeding the hazard unit.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned NREG = NREG_DEFAULT,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            clr_valid,
  input  logic [AW-1:0]   clr_idx,
  input  logic            set_valid,
  input  logic [AW-1:0]   set_idx,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] pending_nxt;

  // Clear on writeback, then set on allocation so a newer producer wins.
  always_comb begin
    pending_nxt = pending;
    if (clr_valid && (clr_idx != AW'(ZERO_REG))) pending_nxt[clr_idx] = 1'b0;
    if (set_valid && (set_idx != AW'(ZERO_REG))) pending_nxt[set_idx] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Pending register: reset and flush both drop every outstanding producer.
  always_ff @(posedge clk) begin
    if (!reset)     pending <= '0;
    else if (flush) pending <= '0;
    else            pending <= pending_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file with pending-write
// scoreboard. Optional same-cycle write-to-read bypass: REGFILE_BYPASS_EN.
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN = XLEN_DEFAULT,
  parameter  int unsigned NREG = NREG_DEFAULT,
  parameter  int unsigned NRD  = 2,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWrite,
  input  logic [AW-1:0]       WriteRegister,
  input  logic [XLEN-1:0]     WriterData,
  input  logic [NRD*AW-1:0]   ReadRegister,
  output logic [NRD*XLEN-1:0] ReadData,
  output logic [NRD-1:0]      ReadBusy,
  input  logic                AllocValid,
  input  logic [AW-1:0]       AllocRegister,
  input  logic                Flush
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pending;
  logic            wr_en;
  logic [AW-1:0]   idx;

  assign wr_en = RegWrite && (WriteRegister != AW'(ZERO_REG));

  rf_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .flush     (Flush),
    .clr_valid (RegWrite),
    .clr_idx   (WriteRegister),
    .set_valid (AllocValid),
    .set_idx   (AllocRegister),
    .pending   (pending)
  );

  // Register storage: cleared on reset, single write port from writeback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[WriteRegister] <= WriterData;
    end
  end

  // Combinational read ports with busy lookup; everything forced to 0 in reset.
  always_comb begin
    ReadData = '0;
    ReadBusy = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      idx = ReadRegister[k*AW +: AW];
      if (idx != AW'(ZERO_REG)) begin
        ReadData[k*XLEN +: XLEN] = mem[idx];
        ReadBusy[k]              = pending[idx];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (WriteRegister == idx)) begin
        ReadData[k*XLEN +: XLEN] = WriterData;
        ReadBusy[k]              = AllocValid && !Flush && (AllocRegister == idx);
      end
`endif
      if (!reset) begin
        ReadData[k*XLEN +: XLEN] = '0;
        ReadBusy[k]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NRD=4); expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 4;
  localparam int unsigned AW   = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                RegWrite = 1'b0;
  logic [AW-1:0]       WriteRegister = '0;
  logic [XLEN-1:0]     WriterData = '0;
  logic [NRD*AW-1:0]   ReadRegister = '0;
  logic [NRD*XLEN-1:0] ReadData;
  logic [NRD-1:0]      ReadBusy;
  logic                AllocValid = 1'b0;
  logic [AW-1:0]       AllocRegister = '0;
  logic                Flush = 1'b0;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriterData    (WriterData),
    .ReadRegister  (ReadRegister),
    .ReadData      (ReadData),
    .ReadBusy      (ReadBusy),
    .AllocValid    (AllocValid),
    .AllocRegister (AllocRegister),
    .Flush         (Flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            wr;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            al;
    logic [AW-1:0]   aa;
    logic            fl;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
    logic            b0;
    logic            b1;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rd(input int k);
    return ReadData[k*XLEN +: XLEN];
  endfunction

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    ReadRegister = {a3, a2, a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0; AllocValid = 1'b0; Flush = 1'b0;
  endtask

  logic [XLEN-1:0] byp_exp;

  initial begin
    // Directed vectors: outputs checked before the edge that commits the inputs.
    vecs[0]  = '{"wr_x1",        1, 5'd1,  32'd2,          0, 5'd0, 0, 5'd0,  5'd0,  32'd0,    32'd0,          0, 0};
    vecs[1]  = '{"wr_x31",       1, 5'd31, 32'hDEADBEEF,   0, 5'd0, 0, 5'd1,  5'd0,  32'd2,    32'd0,          0, 0};
    vecs[2]  = '{"wr_x0",        1, 5'd0,  32'hFFFFFFFF,   0, 5'd0, 0, 5'd1,  5'd31, 32'd2,    32'hDEADBEEF,   0, 0};
    vecs[3]  = '{"x0_zero",      0, 5'd0,  32'd0,          0, 5'd0, 0, 5'd0,  5'd31, 32'd0,    32'hDEADBEEF,   0, 0};
    vecs[4]  = '{"alloc_x5",     0, 5'd0,  32'd0,          1, 5'd5, 0, 5'd1,  5'd31, 32'd2,    32'hDEADBEEF,   0, 0};
    vecs[5]  = '{"x5_busy_c1",   0, 5'd0,  32'd0,          0, 5'd0, 0, 5'd5,  5'd1,  32'd0,    32'd2,          1, 0};
    vecs[6]  = '{"x5_busy_c2",   0, 5'd0,  32'd0,          0, 5'd0, 0, 5'd5,  5'd5,  32'd0,    32'd0,          1, 1};
    vecs[7]  = '{"wb_x5",        1, 5'd5,  32'd7,          0, 5'd0, 0, 5'd1,  5'd31, 32'd2,    32'hDEADBEEF,   0, 0};
    vecs[8]  = '{"alloc_x0",     0, 5'd0,  32'd0,          1, 5'd0, 0, 5'd5,  5'd0,  32'd7,    32'd0,          0, 0};
    vecs[9]  = '{"wb_alloc_x6",  1, 5'd6,  32'h66,         1, 5'd6, 0, 5'd0,  5'd5,  32'd0,    32'd7,          0, 0};
    vecs[10] = '{"flush_alloc7", 0, 5'd0,  32'd0,          1, 5'd7, 1, 5'd6,  5'd7,  32'h66,   32'd0,          1, 0};
    vecs[11] = '{"after_flush",  0, 5'd0,  32'd0,          0, 5'd0, 0, 5'd6,  5'd7,  32'h66,   32'd0,          0, 0};
    vecs[12] = '{"flush_wr_x8",  1, 5'd8,  32'h88,         0, 5'd0, 1, 5'd6,  5'd0,  32'h66,   32'd0,          0, 0};
    vecs[13] = '{"x8_written",   0, 5'd0,  32'd0,          0, 5'd0, 0, 5'd8,  5'd6,  32'h88,   32'h66,         0, 0};

    // Test 1: fill with random data and a pending bit, then hold reset for 2 cycles.
    reset = 1'b1;
    step();
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1'b1; WriteRegister = AW'(i); WriterData = $urandom;
      AllocValid = (i == 4); AllocRegister = 5'd4;
      step();
    end
    idle();
    set_rd(5'd4, 5'd4, 5'd4, 5'd4);
    #1;
    check("pre_reset_busy_x4", 32'(ReadBusy), 32'hF);
    RegWrite = 1'b1; WriteRegister = 5'd2; WriterData = 32'h1234;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_rd(5'd1, 5'd2, 5'd31, 5'd4);
      #1;
      for (int k = 0; k < 4; k++) check("in_reset_data", rd(k), 32'd0);
      check("in_reset_busy", 32'(ReadBusy), 32'd0);
      step();
    end
    reset = 1'b1;
    idle();
    for (int g = 0; g < 8; g++) begin
      set_rd(AW'(4*g), AW'(4*g+1), AW'(4*g+2), AW'(4*g+3));
      #1;
      for (int k = 0; k < 4; k++) check($sformatf("post_reset_x%0d", 4*g+k), rd(k), 32'd0);
      check($sformatf("post_reset_busy_g%0d", g), 32'(ReadBusy), 32'd0);
    end

    // Tests 2-4: table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      RegWrite = vecs[i].wr; WriteRegister = vecs[i].wa; WriterData = vecs[i].wd;
      AllocValid = vecs[i].al; AllocRegister = vecs[i].aa; Flush = vecs[i].fl;
      set_rd(vecs[i].ra0, vecs[i].ra1, 5'd0, 5'd0);
      #1;
      check({vecs[i].name, "_p0"}, rd(0), vecs[i].e0);
      check({vecs[i].name, "_p1"}, rd(1), vecs[i].e1);
      check({vecs[i].name, "_busy"}, 32'(ReadBusy), 32'({2'b00, vecs[i].b1, vecs[i].b0}));
      step();
    end
    idle();

    // Test 5: reset dominates a pending register and a same-cycle write.
    AllocValid = 1'b1; AllocRegister = 5'd9;
    step();
    idle();
    set_rd(5'd9, 5'd1, 5'd0, 5'd0);
    #1;
    check("x9_pending", 32'(ReadBusy), 32'h1);
    reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd9; WriterData = 32'd5;
    #1;
    check("rst_mid_x9_busy", 32'(ReadBusy), 32'd0);
    check("rst_mid_x1", rd(1), 32'd0);
    step();
    reset = 1'b1;
    idle();
    #1;
    check("after_rst_x9", rd(0), 32'd0);
    check("after_rst_x1", rd(1), 32'd0);
    check("after_rst_busy", 32'(ReadBusy), 32'd0);

    // Test 6: same-cycle write-to-read on all four ports.
    RegWrite = 1'b1; WriteRegister = 5'd3; WriterData = 32'h11;
    step();
    WriterData = 32'h55;
    set_rd(5'd3, 5'd3, 5'd3, 5'd3);
    #1;
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'h11;
`endif
    for (int k = 0; k < 4; k++) check($sformatf("byp_same_p%0d", k), rd(k), byp_exp);
    check("byp_same_busy", 32'(ReadBusy), 32'd0);
    step();
    idle();
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("byp_next_p%0d", k), rd(k), 32'h55);

    // Write plus allocation to the same register: busy stays up, set wins.
    RegWrite = 1'b1; WriteRegister = 5'd3; WriterData = 32'h77;
    AllocValid = 1'b1; AllocRegister = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'h77;
    check("byp_alloc_busy", 32'(ReadBusy), 32'hF);
`else
    byp_exp = 32'h55;
    check("byp_alloc_busy", 32'(ReadBusy), 32'h0);
`endif
    check("byp_alloc_data", rd(2), byp_exp);
    step();
    idle();
    #1;
    check("alloc_after_data", rd(3), 32'h77);
    check("alloc_after_busy", 32'(ReadBusy), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the five-stage RISC-V pipeline; successor to the fixed 2R1W RegisterFile.
- Sits between decode (reads, destination allocation) and writeback (write port).
- Adds three things over the fixed block: configurable width, depth and read-port count; a per-register pending-write scoreboard that feeds the hazard unit; optional write-to-read bypass.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports, 1..4.
- AW, $clog2(NREG), register address width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- RegWrite  input  1  writeback write enable.
- WriteRegister  input  AW  writeback destination index.
- WriterData  input  XLEN  writeback data.
- ReadRegister  input  NRD*AW  read indices; port k occupies bits [k*AW +: AW].
- ReadData  output  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- ReadBusy  output  NRD  bit k is 1 when the register on port k has an outstanding producer.
- AllocValid  input  1  decode issued an instruction that writes AllocRegister.
- AllocRegister  input  AW  destination being allocated.
- Flush  input  1  pipeline flush; clears all pending bits.

Behaviour:
- Storage: NREG x XLEN flops plus an NREG-bit pending vector. Register 0 reads as 0 and is never pending; writes and allocations to index 0 are ignored.
- Reset: on a rising clk edge with reset==0, all registers and all pending bits are cleared. Reset dominates every other input in that cycle. While reset is low: ReadData = 0 for every port, ReadBusy = 0.
- Write: on a rising clk edge with reset==1, RegWrite==1 and WriteRegister!=0, mem[WriteRegister] <= WriterData. Write latency is 1 cycle.
- Read: combinational, zero latency: ReadData[k] = mem[ReadRegister[k]]. Index 0 returns 0 on every port.
- ReadBusy[k] = pending[ReadRegister[k]]; combinational; always 0 for index 0.
- Pending update, applied per edge in this priority order:
  1. !reset: all pending bits cleared.
  2. Flush: all pending bits cleared; any same-cycle allocation is discarded; the data write still happens.
  3. Otherwise:
     - RegWrite to r clears pending[r].
     - AllocValid to r sets pending[r].
     - If both target the same r in the same cycle, set wins, because the newer producer is outstanding.
- No pending counter: a second allocation to an already-pending register keeps it pending, and the first writeback clears it. The hazard unit must not issue a second producer to a register before the first one retires.
- Out-of-range indices cannot occur because AW is exact.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if RegWrite==1, WriteRegister!=0 and WriteRegister==ReadRegister[k], then ReadData[k] = WriterData and ReadBusy[k] = 0 in the same cycle (write-then-read within one cycle). Exception: a same-cycle AllocValid to that register keeps ReadBusy[k]=1.
- Undefined: reads return the old value until the next edge. The external forwarding unit covers the writeback-to-decode hazard.

Decomposition:
- Package rf_pkg holds:
  - XLEN_DEFAULT, NREG_DEFAULT, NRD_MAX constants;
  - a typedef for register index and data word;
  - the ZERO_REG = 0 constant.
- One sub-module, rf_scoreboard: the pending vector and its set/clear/flush logic, which exports pending[NREG-1:0].
- Storage and read muxes stay in regfile_mp.

Test Plan:
1. Reset low for 2 cycles after writing random data, then release. Required: every read port returns 0 and ReadBusy = 0 for all 32 indices.
2. Write x1=32'd2, then x31=32'hDEADBEEF. Read with port0=1, port1=31. Required: 2 and DEADBEEF from the next cycle onward. Then write x0=32'hFFFF_FFFF. Required: x0 still reads 0.
3. Alloc x5 at cycle 0. Required: ReadBusy=1 while reading x5. Writeback x5=7 at cycle 3. Required: ReadBusy=0 from cycle 4 and data=7. Alloc x0. Required: ReadBusy stays 0.
4. Writeback x6 and alloc x6 in the same cycle. Required: pending[6]=1 after the edge. Flush plus alloc x7 in the same cycle. Required: no pending bits set.
5. Reset low mid-operation with x9 pending and RegWrite x9=5 asserted. Required: x9=0 and not pending after the edge.
6. With REGFILE_BYPASS_EN: write x3=32'h55 while reading x3 on all NRD=4 ports. Required: 32'h55 in the same cycle. Without the macro: the old value in that cycle, 32'h55 on the next.
